// File: rtl/qusoc_io_pkg.sv
// Shared definitions for the QuSoC board I/O blocks: debouncer FSM states
// and the default debounce interval.
package qusoc_io_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    PRESS_CHECK   = 2'd1,
    HELD          = 2'd2,
    RELEASE_CHECK = 2'd3
  } db_state_t;

  // 1 ms at a 16 MHz system clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16000;

endpackage

// File: rtl/input_synchronizer.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to
// RESET_VALUE so the first synchronized samples after reset are predictable.
module input_synchronizer #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic Clock,
  input  logic ResetN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes the pin, accepts a level change only
// after DEBOUNCE_CYCLES stable samples, and keeps a press counter and event flag.
module button_debouncer
  import qusoc_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned COUNT_WIDTH     = 16,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                   Clock,
  input  logic                   ResetN,
  input  logic                   Button,
  output logic                   Level,
  output logic                   Pressed,
  output logic                   Released,
  output logic [COUNT_WIDTH-1:0] PressCount,
  output logic                   EventValid,
  input  logic                   EventAck,
  output logic                   Overrun,
  output db_state_t              dbg_state
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q;
  logic          raw;
  db_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          press_accept;
  logic          release_accept;

  // Reset value matches the released pin so reset never looks like a press.
  input_synchronizer #(
    .RESET_VALUE (ACTIVE_LOW)
  ) u_sync (
    .Clock  (Clock),
    .ResetN (ResetN),
    .d      (Button),
    .q      (sync_q)
  );

  assign raw       = sync_q ^ ACTIVE_LOW;
  assign dbg_state = state;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    press_accept   = 1'b0;
    release_accept = 1'b0;
    case (state)
      IDLE: begin
        if (raw) begin
          state_next = PRESS_CHECK;
          cnt_next   = '0;
        end
      end
      PRESS_CHECK: begin
        if (!raw) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = HELD;
          cnt_next     = '0;
          press_accept = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!raw) begin
          state_next = RELEASE_CHECK;
          cnt_next   = '0;
        end
      end
      RELEASE_CHECK: begin
        if (raw) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next     = IDLE;
          cnt_next       = '0;
          release_accept = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Handshake: EventValid rises with an accepted press and stays high until an
  // edge sees EventAck & EventValid; EventAck alone is ignored. A press that
  // lands on an unacknowledged event (no EventAck that edge) sets sticky
  // Overrun; a press coinciding with EventAck replaces the event cleanly.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      Level      <= 1'b0;
      Pressed    <= 1'b0;
      Released   <= 1'b0;
      PressCount <= '0;
      EventValid <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      Pressed  <= press_accept;
      Released <= release_accept;
      if (press_accept) begin
        Level      <= 1'b1;
        PressCount <= PressCount + 1'b1;
        EventValid <= 1'b1;
        if (EventValid && !EventAck) Overrun <= 1'b1;
      end else begin
        if (release_accept) Level <= 1'b0;
        if (EventAck && EventValid) EventValid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16000, stable-sample count before a level change is accepted (1 ms at 16 MHz); legal range 2..2^20.
REQ-002 Parameter COUNT_WIDTH, default 16, width of PressCount.
REQ-003 Parameter ACTIVE_LOW, default 1; 1 = pin reads 0 when pressed (pull-up button).
REQ-004 Clock  input  1  single system clock; all state updates on rising edge.
REQ-005 ResetN  input  1  asynchronous, active-low reset; one clock, no other clock domains.
REQ-006 Button  input  1  raw asynchronous board pin.
REQ-007 Level  output  1  debounced state, 1 = pressed.
REQ-008 Pressed  output  1  one-cycle pulse on accepted press.
REQ-009 Released  output  1  one-cycle pulse on accepted release.
REQ-010 PressCount  output  COUNT_WIDTH  accepted presses since reset.
REQ-011 EventValid  output  1  pending press event for SoC.
REQ-012 EventAck  input  1  SoC consumes pending event.
REQ-013 Overrun  output  1  sticky: press accepted while previous event unconsumed.

Function
REQ-014 Button SHALL pass a 2-flop synchronizer; raw = sync output XOR ACTIVE_LOW, so raw = 1 means pressed.
REQ-015 FSM states SHALL be IDLE, PRESS_CHECK, HELD, RELEASE_CHECK.
REQ-016 IDLE: raw = 1 -> PRESS_CHECK, stable counter cleared to 0.
REQ-017 PRESS_CHECK: raw = 0 -> IDLE, counter cleared; raw = 1 and counter = DEBOUNCE_CYCLES-1 -> HELD, Level set, Pressed pulsed; otherwise counter increments.
REQ-018 HELD and RELEASE_CHECK SHALL mirror REQ-016/017 with raw inverted; acceptance clears Level and pulses Released.
REQ-019 Latency: for a clean step on Button sampled at edge 1, Level SHALL change exactly at edge DEBOUNCE_CYCLES+3.
REQ-020 Any glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no Level change and no pulse.
REQ-021 Pressed and Released SHALL never be high in the same cycle; each is high for exactly one cycle per accepted transition.
REQ-022 PressCount SHALL increment on Pressed and wrap from 2^COUNT_WIDTH-1 to 0 without flag.
REQ-023 EventValid SHALL set on Pressed and clear on the edge where EventAck = 1 and EventValid = 1; EventAck while EventValid = 0 SHALL be ignored.
REQ-024 Pressed with EventValid = 1 and EventAck = 0 SHALL set Overrun; EventValid remains 1.
REQ-025 Pressed with EventValid = 1 and EventAck = 1 in the same cycle SHALL leave EventValid = 1 and SHALL NOT set Overrun.
REQ-026 Overrun SHALL clear only on reset.

Reset
REQ-027 ResetN low SHALL immediately force: FSM IDLE, counter 0, Level 0, Pressed 0, Released 0, PressCount 0, EventValid 0, Overrun 0.
REQ-028 Synchronizer flops SHALL reset to the released pin value (ACTIVE_LOW) so no false press follows reset.
REQ-029 Reset asserted mid-debounce or while HELD SHALL abort without emitting Released; a button held through reset release SHALL be reported as a new press after full debounce.

Structure
REQ-030 Shared package qusoc_io_pkg SHALL hold the FSM state enum and the default DEBOUNCE_CYCLES constant.
REQ-031 The 2-flop synchronizer SHALL be a sub-module input_synchronizer (parameterized reset value); remaining logic in button_debouncer.
REQ-032 Stable counter width SHALL be clog2(DEBOUNCE_CYCLES); no other arithmetic wider than COUNT_WIDTH.

Verification (DEBOUNCE_CYCLES = 4, COUNT_WIDTH = 4, ACTIVE_LOW = 1)
REQ-033 Button 1->0 step at edge 1 -> Level = 1 and Pressed pulse at edge 7, PressCount = 1, EventValid = 1.
REQ-034 Button low for 3 cycles then high -> Level stays 0, no pulses, PressCount unchanged.
REQ-035 Two presses without EventAck -> Overrun = 1 after second Pressed; then EventAck -> EventValid = 0, Overrun stays 1.
REQ-036 EventAck in same cycle as second Pressed -> EventValid = 1, Overrun = 0.
REQ-037 17 press/release cycles -> PressCount = 1 after wrap; Released pulses counted = 17.
REQ-038 ResetN asserted while HELD, button kept pressed -> all outputs 0 during reset, no Released; after deassertion Pressed occurs at DEBOUNCE_CYCLES+3 edges.
